bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one single-port BRAM (1-cycle read latency, bram_en/bram_we/bram_addr/bram_wrdata/bram_rddata) between NUM_PORTS requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Sits between several BRAM-style masters (AXI-lite BRAM controllers, DMA engines) and one BRAM macro.
- Round-robin arbitration, at most one BRAM access per cycle, per-port response buffering so no port can stall another.

Parameters:
- NUM_PORTS, 2, number of requesters (>=2).
- DATA_WIDTH, 64, BRAM data width in bits (multiple of 8).
- ADDR_WIDTH, 16, BRAM word-address width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  NUM_PORTS  per-port request valid.
- req_ready  output  NUM_PORTS  per-port request accepted (grant).
- req_addr  input  NUM_PORTS*ADDR_WIDTH  per-port word address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_we  input  NUM_PORTS*DATA_WIDTH/8  per-port byte write enables; all-zero means read.
- req_wrdata  input  NUM_PORTS*DATA_WIDTH  per-port write data.
- rsp_valid  output  NUM_PORTS  per-port response valid.
- rsp_ready  input  NUM_PORTS  per-port response consumed.
- rsp_data  output  NUM_PORTS*DATA_WIDTH  per-port read data; zero for write responses.
- bram_en  output  1  BRAM enable.
- bram_we  output  DATA_WIDTH/8  BRAM byte write enables.
- bram_addr  output  ADDR_WIDTH  BRAM address.
- bram_wrdata  output  DATA_WIDTH  BRAM write data.
- bram_rddata  input  DATA_WIDTH  BRAM read data, valid the cycle after an enabled read only.

Behaviour:
- Clocking: single clock clk. rstn is asynchronous active-low. All state clears on rstn low: rsp_valid=0, latched flags=0, write flags=0, round-robin pointer=0.
- Slot availability: slot_free[i] = !rsp_valid[i] || rsp_ready[i]. A port can be granted in the same cycle its previous response is consumed.
- Eligibility: eligible[i] = req_valid[i] && slot_free[i].
- Grant: exactly one eligible port, the first found scanning from pointer upward with wrap-around (pointer, pointer+1, ..., NUM_PORTS-1, 0, ...).
  - req_ready is one-hot or zero and combinational from req_valid, rsp_valid and rsp_ready.
  - req_ready[i] never depends on req_valid of another port being low beyond the scan order.
- Pointer: after a grant to port g, pointer <= (g+1) mod NUM_PORTS. With no grant, pointer holds.
- BRAM drive, with g the granted port:
  - bram_en = any grant.
  - bram_addr/bram_we/bram_wrdata = port g's fields.
  - bram_we = 0 when there is no grant. Address and data are don't-care when there is no grant.
- Latency: a request accepted in cycle T gives rsp_valid[g]=1 in cycle T+1. Every request, read or write, produces exactly one response beat.
- Response data:
  - Read: in T+1, rsp_data[g] = bram_rddata, combinational pass-through.
  - If rsp_ready[g]=0 in T+1, bram_rddata is captured into port g's latch at end of T+1. From T+2, rsp_data[g] = latched data, held stable until consumed.
  - Write: rsp_data[g] = 0 for that beat.
- Consumption: rsp_valid[i] && rsp_ready[i] clears rsp_valid[i] and the latch flag, unless port i is granted in the same cycle, in which case rsp_valid[i] stays 1 for the new response.
- Invariants:
  - At most one port is in the "fresh" state (rsp_valid && !latched) at a time.
  - rsp_valid/rsp_data stay stable while rsp_ready=0 (AXI-style).
- Simultaneous requests from all ports: strict rotation, each port granted once per NUM_PORTS cycles when all keep valid high and consume responses.
- A port with rsp_valid=1 and rsp_ready=0 is skipped; other ports proceed at full rate.
- Reset mid-operation:
  - A BRAM write issued before reset completes in the BRAM.
  - Pending responses are dropped, and rsp_valid=0 immediately on rstn low.
- No reordering within a port. At most one outstanding response per port.

Decomposition:
- Shared package bram_pkg holds no new typedefs; the block uses plain vectors. Parameter legality (NUM_PORTS>=2, DATA_WIDTH%8==0) is checked in an initial assertion with $fatal.
- One sub-module, rr_arbiter (parameters NUM_PORTS):
  - Inputs: request vector, advance strobe.
  - Outputs: one-hot grant, granted index.
  - Owns the pointer register.
  - Reusable by other shared-resource blocks.

Test Plan:
- Single read: port0 reads addr 0x0010 holding 0xDEADBEEF_00000001, rsp_ready=1 → bram_en=1, bram_we=0 in T; rsp_valid[0]=1 with that data in T+1, rsp_valid[0]=0 in T+2.
- Write then read: port1 writes 0x1234 with we=8'h0F, data 0xAAAA_BBBB_CCCC_DDDD over 0xFFFF_FFFF_FFFF_FFFF → write response data 0; a following read returns 0xFFFF_FFFF_CCCC_DDDD.
- Fairness: all ports assert reads every cycle with rsp_ready=1 → grants 0,1,0,1,... (NUM_PORTS=2); bram_en high every cycle; no port starves.
- Back-pressure: port0 holds rsp_ready=0 for 5 cycles after a read of 0x55 → rsp_data[0] stays 0x55 while bram_rddata changes; port1 is granted every cycle meanwhile; port0 is granted again in the same cycle it finally consumes.
- Consume-and-reissue: port0 rsp_ready=1 and req_valid=1 continuously → one grant per 2 cycles when contending, rsp_valid[0] never drops between back-to-back grants.
- Reset mid-stream: assert rstn low while rsp_valid[1]=1 and latched → rsp_valid=0 immediately; after release the first grant goes to port 0.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared helpers for BRAM-sharing blocks: index sizing and round-robin wrap.
package bram_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the
// pointer moves just past the winner whenever advance is strobed.
module rr_arbiter
  import bram_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int               sum;
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default before the loop, so no path leaves one unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    sum       = 0;
    idx       = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      sum = int'(ptr_q) + off;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      idx = IDX_W'(sum);
      if (grant == '0 && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    ptr_d = ptr_q;
    if (advance && (req != '0)) ptr_d = IDX_W'(rr_next(int'(grant_idx), NUM_PORTS));
  end

  // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM among NUM_PORTS valid/ready requesters with
// round-robin grants and a one-beat response buffer per port.
module bram_port_arbiter
  import bram_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_we,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wrdata,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  input  logic [NUM_PORTS-1:0]              rsp_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   rsp_data,
  output logic                              bram_en,
  output logic [DATA_WIDTH/8-1:0]           bram_we,
  output logic [ADDR_WIDTH-1:0]             bram_addr,
  output logic [DATA_WIDTH-1:0]             bram_wrdata,
  input  logic [DATA_WIDTH-1:0]             bram_rddata
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = idx_width(NUM_PORTS);

  if (NUM_PORTS < 2) begin : g_bad_ports
    $fatal(1, "bram_port_arbiter: NUM_PORTS must be >= 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $fatal(1, "bram_port_arbiter: DATA_WIDTH must be a multiple of 8");
  end

  logic [NUM_PORTS-1:0]  slot_free, eligible, grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
  logic [NUM_PORTS-1:0]  latched_q, latched_d;
  logic [NUM_PORTS-1:0]  is_wr_q, is_wr_d;
  logic [DATA_WIDTH-1:0] data_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] data_d [NUM_PORTS];

  // A slot being drained this cycle may already take the next request.
  assign slot_free = ~rsp_valid_q | rsp_ready;
  assign eligible  = req_valid & slot_free;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .req      (eligible),
    .advance  (|eligible),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign bram_en   = |grant;

  always_comb begin
    bram_addr   = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    bram_wrdata = req_wrdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    bram_we     = bram_en ? req_we[int'(grant_idx)*BE_W +: BE_W] : '0;
  end

  // Only the port granted last cycle is "fresh"; if it stalls, the BRAM output
  // is captured now because it is not guaranteed valid afterwards.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    latched_d   = latched_q;
    is_wr_d     = is_wr_q;
    data_d      = data_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        rsp_valid_d[i] = 1'b1;
        latched_d[i]   = 1'b0;
        is_wr_d[i]     = |req_we[i*BE_W +: BE_W];
      end else if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
        latched_d[i]   = 1'b0;
      end else if (rsp_valid_q[i] && !latched_q[i]) begin
        latched_d[i] = 1'b1;
        data_d[i]    = bram_rddata;
      end
    end
  end

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rsp_valid_q[i] && !is_wr_q[i])
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = latched_q[i] ? data_q[i] : bram_rddata;
    end
  end

  // NOTE: the data latches are reset too; they are few and it keeps rsp_data free of X after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q <= '0;
      latched_q   <= '0;
      is_wr_q     <= '0;
      for (int i = 0; i < NUM_PORTS; i++) data_q[i] <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      latched_q   <= latched_d;
      is_wr_q     <= is_wr_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: BRAM model, spec-level reference model, directed and random steps.
module tb_bram_port_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*BW-1:0] req_we;
  logic [N*DW-1:0] req_wrdata, rsp_data;
  logic            bram_en;
  logic [BW-1:0]   bram_we;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_wrdata, bram_rddata;

  int checks   = 0;
  int failures = 0;

  bram_port_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wrdata (req_wrdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wrdata(bram_wrdata),
    .bram_rddata(bram_rddata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wr,
                                          input logic [BW-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (we[b]) r[b*8 +: 8] = wr[b*8 +: 8];
    return r;
  endfunction

  // BRAM macro: 1-cycle read latency, output is garbage after non-read cycles.
  logic [DW-1:0] bram_mem [0:65535];
  always @(posedge clk) begin
    if (bram_en && bram_we == '0) bram_rddata <= bram_mem[bram_addr];
    else                          bram_rddata <= {$urandom, $urandom};
    if (bram_en && bram_we != '0) bram_mem[bram_addr] <= merge(bram_mem[bram_addr], bram_wrdata, bram_we);
  end

  // Reference model: rotation pointer, one pending response per port, shadow memory.
  logic [DW-1:0] ref_mem [0:65535];
  int            ptr;
  bit            pend      [N];
  logic [DW-1:0] pend_data [N];
  int            exp_g;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input bit v, input logic [AW-1:0] a, input logic [BW-1:0] we,
                       input logic [DW-1:0] d);
    req_valid[p]           = v;
    req_addr[p*AW +: AW]   = a;
    req_we[p*BW +: BW]     = we;
    req_wrdata[p*DW +: DW] = d;
  endtask

  task automatic model_reset();
    ptr = 0;
    for (int p = 0; p < N; p++) begin
      pend[p]      = 1'b0;
      pend_data[p] = '0;
    end
  endtask

  // Let combinational outputs settle, predict the grant, and compare everything visible.
  task automatic settle();
    logic [N-1:0] exp_ready;
    #1;
    exp_g = -1;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (ptr + k) % N;
      if (exp_g < 0 && req_valid[p] && (!pend[p] || rsp_ready[p])) exp_g = p;
    end
    exp_ready = '0;
    if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
    check("req_ready", 128'(req_ready), 128'(exp_ready));
    check("bram_en", 128'(bram_en), 128'(exp_g >= 0));
    if (exp_g >= 0) begin
      check("bram_we", 128'(bram_we), 128'(req_we[exp_g*BW +: BW]));
      check("bram_addr", 128'(bram_addr), 128'(req_addr[exp_g*AW +: AW]));
      check("bram_wrdata", 128'(bram_wrdata), 128'(req_wrdata[exp_g*DW +: DW]));
    end else begin
      check("bram_we_idle", 128'(bram_we), 128'(0));
    end
    for (int p = 0; p < N; p++) begin
      check($sformatf("rsp_valid[%0d]", p), 128'(rsp_valid[p]), 128'(pend[p]));
      if (pend[p]) check($sformatf("rsp_data[%0d]", p), 128'(rsp_data[p*DW +: DW]), 128'(pend_data[p]));
    end
  endtask

  // Clock edge, then the model applies the same cycle's accept/consume rules.
  task automatic advance();
    @(posedge clk);
    for (int p = 0; p < N; p++) begin
      if (p == exp_g) begin
        logic [AW-1:0] a;
        logic [BW-1:0] we;
        a  = req_addr[p*AW +: AW];
        we = req_we[p*BW +: BW];
        pend[p] = 1'b1;
        if (we == '0) begin
          pend_data[p] = ref_mem[a];
        end else begin
          pend_data[p] = '0;
          ref_mem[a]   = merge(ref_mem[a], req_wrdata[p*DW +: DW], we);
        end
      end else if (pend[p] && rsp_ready[p]) begin
        pend[p] = 1'b0;
      end
    end
    if (exp_g >= 0) ptr = (exp_g + 1) % N;
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] want;
    rstn = 1'b0;
    req_valid = '0; req_addr = '0; req_we = '0; req_wrdata = '0; rsp_ready = '0;
    model_reset();
    #1;
    check("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    check("reset_req_ready", 128'(req_ready), 128'(0));
    check("reset_bram_en", 128'(bram_en), 128'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rsp_ready = '1;

    // Preload through the DUT so BRAM and shadow memory start out identical.
    for (int k = 0; k < 16; k++) begin
      drive(k % N, 1'b1, AW'(k), '1, {$urandom, $urandom});
      drive((k + 1) % N, 1'b0, '0, '0, '0);
      settle(); advance();
    end
    drive(1, 1'b0, '0, '0, '0);
    drive(0, 1'b1, 16'h0010, '1, 64'hDEAD_BEEF_0000_0001); settle(); advance();
    drive(0, 1'b1, 16'h1234, '1, 64'hFFFF_FFFF_FFFF_FFFF); settle(); advance();
    drive(0, 1'b1, 16'h0020, '1, 64'h0000_0000_0000_0055); settle(); advance();
    drive(0, 1'b0, '0, '0, '0); settle(); advance();

    // Single read on port 0.
    drive(0, 1'b1, 16'h0010, '0, '0);
    settle();
    check("t1_en", 128'(bram_en), 128'(1));
    check("t1_we", 128'(bram_we), 128'(0));
    advance();
    drive(0, 1'b0, '0, '0, '0);
    settle();
    check("t1_rsp_valid", 128'(rsp_valid[0]), 128'(1));
    check("t1_rsp_data", 128'(rsp_data[63:0]), 128'(64'hDEAD_BEEF_0000_0001));
    advance();
    settle();
    check("t1_rsp_drop", 128'(rsp_valid[0]), 128'(0));
    advance();

    // Partial write then read-back on port 1.
    drive(1, 1'b1, 16'h1234, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD);
    settle(); advance();
    drive(1, 1'b1, 16'h1234, '0, '0);
    settle();
    check("t2_wr_valid", 128'(rsp_valid[1]), 128'(1));
    check("t2_wr_data", 128'(rsp_data[127:64]), 128'(0));
    advance();
    drive(1, 1'b0, '0, '0, '0);
    settle();
    check("t2_rd_data", 128'(rsp_data[127:64]), 128'(64'hFFFF_FFFF_CCCC_DDDD));
    advance();

    // Fairness: both ports read every cycle.
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'b1, AW'(k), '0, '0);
      drive(1, 1'b1, AW'(k + 8), '0, '0);
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      settle();
      check("t3_grant", 128'(req_ready), 128'(want));
      check("t3_en", 128'(bram_en), 128'(1));
      advance();
    end

    // Back-pressure on port 0 while port 1 streams.
    drive(0, 1'b1, 16'h0020, '0, '0);
    settle();
    check("t4_grant0", 128'(req_ready), 128'(2'b01));
    advance();
    rsp_ready[0] = 1'b0;
    for (int h = 0; h < 5; h++) begin
      drive(1, 1'b1, AW'($urandom_range(0, 15)), '0, '0);
      settle();
      check("t4_grant1", 128'(req_ready), 128'(2'b10));
      check("t4_hold", 128'(rsp_data[63:0]), 128'(64'h55));
      advance();
    end
    rsp_ready[0] = 1'b1;
    settle();
    check("t4_regrant", 128'(req_ready), 128'(2'b01));
    check("t4_final", 128'(rsp_data[63:0]), 128'(64'h55));
    advance();

    // Port 0 alone, back-to-back grants keep rsp_valid high.
    drive(1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 16'h0010, '0, '0);
      settle();
      check("t5_grant", 128'(req_ready), 128'(2'b01));
      check("t5_valid", 128'(rsp_valid[0]), 128'(1));
      advance();
    end

    // Reset while port 1 holds a latched response, after a port 0 write.
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 16'h0010, '0, '0);
    settle(); advance();
    drive(1, 1'b0, '0, '0, '0);
    drive(0, 1'b1, 16'h0030, '1, 64'h0123_4567_89AB_CDEF);
    rsp_ready = 2'b01;
    settle(); advance();
    drive(0, 1'b0, '0, '0, '0);
    settle();
    check("t6_latched", 128'(rsp_data[127:64]), 128'(64'hDEAD_BEEF_0000_0001));
    rstn = 1'b0;
    req_valid = '0;
    #1;
    check("t6_rst_valid", 128'(rsp_valid), 128'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    rsp_ready = '1;
    drive(0, 1'b1, 16'h0030, '0, '0);
    drive(1, 1'b1, 16'h0010, '0, '0);
    settle();
    check("t6_first_grant", 128'(req_ready), 128'(2'b01));
    advance();
    drive(0, 1'b0, '0, '0, '0);
    settle();
    check("t6_write_kept", 128'(rsp_data[63:0]), 128'(64'h0123_4567_89AB_CDEF));
    advance();

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        drive(p, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)),
              ($urandom_range(0, 1) != 0) ? BW'(0) : BW'($urandom_range(1, 255)),
              {$urandom, $urandom});
        rsp_ready[p] = $urandom_range(0, 3) != 0;
      end
      settle(); advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
